// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared states, opcode constants and instruction classes for control_sequencer
// Purpose: types and constants shared by control_sequencer and opcode_class.
// Ports: none (package).
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_PAUSE,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU3,
        C_ALUI,
        C_LDI,
        C_LD,
        C_ST,
        C_BR,
        C_JR,
        C_NOP,
        C_HALT
    } iclass_t;

    localparam logic [4:0] OP_LD         = 5'b00000;
    localparam logic [4:0] OP_LDI        = 5'b00001;
    localparam logic [4:0] OP_ST         = 5'b00010;
    localparam logic [4:0] OP_ALU3_FIRST = 5'b00011;
    localparam logic [4:0] OP_ALU3_LAST  = 5'b01011;
    localparam logic [4:0] OP_ADDI       = 5'b01100;
    localparam logic [4:0] OP_ANDI       = 5'b01101;
    localparam logic [4:0] OP_ORI        = 5'b01110;
    localparam logic [4:0] OP_BR         = 5'b10011;
    localparam logic [4:0] OP_JR         = 5'b10100;
    localparam logic [4:0] OP_NOP        = 5'b11010;
    localparam logic [4:0] OP_HALT       = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_INC = 5'b11111;

endpackage

// File: rtl/control_sequencer_opcode_class.sv
// rtl/control_sequencer_opcode_class.sv - combinational opcode to instruction-class decoder
// Purpose: map a 5-bit opcode to the instruction class that selects the T3..T7 sequence.
// Ports: opcode (in, 5) - ir[31:27]; iclass (out) - decoded class, unsupported opcodes decode as C_NOP.
module opcode_class
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_t    iclass
);

    always_comb begin
        iclass = C_NOP;
        if (opcode >= OP_ALU3_FIRST && opcode <= OP_ALU3_LAST) begin
            iclass = C_ALU3;
        end else begin
            case (opcode)
                OP_LD:                    iclass = C_LD;
                OP_LDI:                   iclass = C_LDI;
                OP_ST:                    iclass = C_ST;
                OP_ADDI, OP_ANDI, OP_ORI: iclass = C_ALUI;
                OP_BR:                    iclass = C_BR;
                OP_JR:                    iclass = C_JR;
                OP_HALT:                  iclass = C_HALT;
                default:                  iclass = C_NOP;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Moore control-step sequencer for a single-bus CPU datapath
// Purpose: steps RST/T0..T7/PAUSE/HALT and decodes datapath strobes from state and opcode.
// Ports: clock, reset (async, active-high); ir (32, opcode in [31:27]); con_ff branch condition;
//        mem_ready memory handshake; stop pause request; 1-bit datapath strobes; gra/grb/grc/rin/
//        rout/ba_out register select; run (low in PAUSE/HALT); alu_op (5) ALU operation.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ready,
    input  logic        stop,
    output logic        pc_out,
    output logic        pc_in,
    output logic        inc_pc,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        read,
    output logic        write,
    output logic        ir_in,
    output logic        y_in,
    output logic        zlow_in,
    output logic        zlow_out,
    output logic        c_out,
    output logic        con_in,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        rin,
    output logic        rout,
    output logic        ba_out,
    output logic        run,
    output logic [4:0]  alu_op
);

    state_t  state_q, state_d;
    iclass_t iclass;
    state_t  boundary;
    logic    unused_ir_bits;

    assign unused_ir_bits = ^ir[26:0];

    opcode_class u_opcode_class (
        .opcode (ir[31:27]),
        .iclass (iclass)
    );

    // Every instruction end funnels through here so stop is only honoured between instructions.
    assign boundary = stop ? S_PAUSE : S_T0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1:  state_d = mem_ready ? S_T2 : S_T1;
            S_T2: begin
                case (iclass)
                    C_HALT:  state_d = S_HALT;
                    C_NOP:   state_d = boundary;
                    default: state_d = S_T3;
                endcase
            end
            S_T3:  state_d = (iclass == C_JR) ? boundary : S_T4;
            S_T4:  state_d = S_T5;
            S_T5: begin
                case (iclass)
                    C_LD, C_ST, C_BR: state_d = S_T6;
                    default:          state_d = boundary;
                endcase
            end
            S_T6: begin
                case (iclass)
                    C_LD:    state_d = mem_ready ? S_T7 : S_T6;
                    C_ST:    state_d = S_T7;
                    default: state_d = boundary;
                endcase
            end
            // Only st writes in T7; ld's T7 is a register transfer and does not wait.
            S_T7:    state_d = (iclass != C_ST || mem_ready) ? boundary : S_T7;
            S_PAUSE: state_d = stop ? S_PAUSE : S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        pc_out   = 1'b0;
        pc_in    = 1'b0;
        inc_pc   = 1'b0;
        mar_in   = 1'b0;
        mdr_in   = 1'b0;
        mdr_out  = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        ir_in    = 1'b0;
        y_in     = 1'b0;
        zlow_in  = 1'b0;
        zlow_out = 1'b0;
        c_out    = 1'b0;
        con_in   = 1'b0;
        gra      = 1'b0;
        grb      = 1'b0;
        grc      = 1'b0;
        rin      = 1'b0;
        rout     = 1'b0;
        ba_out   = 1'b0;
        run      = 1'b1;
        alu_op   = 5'b00000;
        case (state_q)
            S_T0: begin
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                zlow_in = 1'b1;
                alu_op  = ALU_INC;
            end
            S_T1: begin
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                read     = 1'b1;
                mdr_in   = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                case (iclass)
                    C_ALU3, C_ALUI: begin grb = 1'b1; rout = 1'b1; y_in = 1'b1; end
                    C_LDI, C_LD, C_ST: begin grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
                    C_BR: begin gra = 1'b1; rout = 1'b1; con_in = 1'b1; end
                    C_JR: begin gra = 1'b1; rout = 1'b1; pc_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (iclass)
                    C_ALU3: begin grc = 1'b1; rout = 1'b1; zlow_in = 1'b1; alu_op = ir[31:27]; end
                    C_ALUI: begin c_out = 1'b1; zlow_in = 1'b1; alu_op = ir[31:27]; end
                    C_LDI, C_LD, C_ST: begin c_out = 1'b1; zlow_in = 1'b1; alu_op = ALU_ADD; end
                    C_BR: begin pc_out = 1'b1; y_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (iclass)
                    C_ALU3, C_ALUI, C_LDI: begin zlow_out = 1'b1; gra = 1'b1; rin = 1'b1; end
                    C_LD, C_ST: begin zlow_out = 1'b1; mar_in = 1'b1; end
                    C_BR: begin c_out = 1'b1; zlow_in = 1'b1; alu_op = ALU_ADD; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (iclass)
                    C_LD: begin read = 1'b1; mdr_in = 1'b1; end
                    C_ST: begin gra = 1'b1; rout = 1'b1; mdr_in = 1'b1; end
                    // Branch target already sits in Z; taking it is just loading PC from Z.
                    C_BR: begin zlow_out = con_ff; pc_in = con_ff; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (iclass)
                    C_LD: begin mdr_out = 1'b1; gra = 1'b1; rin = 1'b1; end
                    C_ST: write = 1'b1;
                    default: ;
                endcase
            end
            S_PAUSE, S_HALT: run = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;

    logic        clock, reset, con_ff, mem_ready, stop;
    logic [31:0] ir;
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write, ir_in, y_in;
    logic zlow_in, zlow_out, c_out, con_in, gra, grb, grc, rin, rout, ba_out, run;
    logic [4:0]  alu_op;
    logic [25:0] actual;

    control_sequencer dut (
        .clock(clock), .reset(reset), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready), .stop(stop),
        .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in), .mdr_in(mdr_in),
        .mdr_out(mdr_out), .read(read), .write(write), .ir_in(ir_in), .y_in(y_in),
        .zlow_in(zlow_in), .zlow_out(zlow_out), .c_out(c_out), .con_in(con_in), .gra(gra),
        .grb(grb), .grc(grc), .rin(rin), .rout(rout), .ba_out(ba_out), .run(run), .alu_op(alu_op)
    );

    assign actual = {alu_op, run, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write,
                     ir_in, y_in, zlow_in, zlow_out, c_out, con_in, gra, grb, grc, rin, rout, ba_out};

    localparam logic [25:0] BA_OUT = 26'd1 << 0,  ROUT = 26'd1 << 1,  RIN = 26'd1 << 2;
    localparam logic [25:0] GRC = 26'd1 << 3,     GRB = 26'd1 << 4,   GRA = 26'd1 << 5;
    localparam logic [25:0] CON_IN = 26'd1 << 6,  C_OUT = 26'd1 << 7, ZLOW_OUT = 26'd1 << 8;
    localparam logic [25:0] ZLOW_IN = 26'd1 << 9, Y_IN = 26'd1 << 10, IR_IN = 26'd1 << 11;
    localparam logic [25:0] WRITE = 26'd1 << 12,  READ = 26'd1 << 13, MDR_OUT = 26'd1 << 14;
    localparam logic [25:0] MDR_IN = 26'd1 << 15, MAR_IN = 26'd1 << 16, INC_PC = 26'd1 << 17;
    localparam logic [25:0] PC_IN = 26'd1 << 18,  PC_OUT = 26'd1 << 19, RUN = 26'd1 << 20;
    localparam logic [25:0] A_INC  = {5'b11111, 21'd0};
    localparam logic [25:0] A_ADD  = {5'b00011, 21'd0};
    localparam logic [25:0] A_ADDI = {5'b01100, 21'd0};
    localparam logic [25:0] A_SUB  = {5'b00100, 21'd0};

    localparam logic [25:0] E_T0 = RUN | PC_OUT | MAR_IN | INC_PC | ZLOW_IN | A_INC;
    localparam logic [25:0] E_T1 = RUN | ZLOW_OUT | PC_IN | READ | MDR_IN;
    localparam logic [25:0] E_T2 = RUN | MDR_OUT | IR_IN;

    localparam logic [31:0] I_LD   = {5'b00000, 27'h0123456};
    localparam logic [31:0] I_LDI  = {5'b00001, 27'h0000042};
    localparam logic [31:0] I_ST   = {5'b00010, 27'h7ffffff};
    localparam logic [31:0] I_ADD  = {5'b00011, 27'h1234567};
    localparam logic [31:0] I_SUB  = {5'b00100, 27'h0000001};
    localparam logic [31:0] I_ADDI = {5'b01100, 27'h0000010};
    localparam logic [31:0] I_BR   = {5'b10011, 27'h0000200};
    localparam logic [31:0] I_JR   = {5'b10100, 27'h0000000};
    localparam logic [31:0] I_NOP  = {5'b11010, 27'h0000000};
    localparam logic [31:0] I_BAD  = {5'b11111, 27'h5555555};
    localparam logic [31:0] I_HALT = {5'b11011, 27'h0000000};

    typedef struct {
        logic [25:0] exp;
        int          id;
    } item_t;

    item_t exp_q[$];
    item_t mon_it;
    int    checks = 0;
    int    errors = 0;
    int    step_id = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_it = exp_q.pop_front();
            checks++;
            if (actual !== mon_it.exp) begin
                errors++;
                $display("FAIL step %0d outputs: got %h required %h", mon_it.id, actual, mon_it.exp);
            end
        end
    end

    task automatic push(input logic [25:0] e);
        item_t it;
        it.exp = e;
        it.id  = step_id;
        step_id++;
        exp_q.push_back(it);
    endtask

    task automatic step(input logic [31:0] i, input logic c, input logic m, input logic s,
                        input logic [25:0] e);
        @(posedge clock);
        #1;
        ir = i; con_ff = c; mem_ready = m; stop = s;
        push(e);
    endtask

    task automatic fetch(input logic [31:0] i);
        step(i, 1'b0, 1'b1, 1'b0, E_T0);
        step(i, 1'b0, 1'b1, 1'b0, E_T1);
        step(i, 1'b0, 1'b1, 1'b0, E_T2);
    endtask

    initial begin
        reset = 1'b1; ir = 32'd0; con_ff = 1'b0; mem_ready = 1'b1; stop = 1'b0;
        @(posedge clock); #1; push(RUN);
        @(posedge clock); #1; reset = 1'b0; push(RUN);

        // add, with junk ir during T0/T1 that must not matter
        step(I_HALT, 0, 1, 0, E_T0);
        step(I_NOP,  0, 1, 0, E_T1);
        step(I_ADD,  0, 1, 0, E_T2);
        step(I_ADD,  0, 1, 0, RUN | GRB | ROUT | Y_IN);
        step(I_ADD,  0, 1, 0, RUN | GRC | ROUT | ZLOW_IN | A_ADD);
        step(I_ADD,  0, 1, 0, RUN | ZLOW_OUT | GRA | RIN);

        // ld: T1 waits one cycle, T6 waits three
        step(I_LD, 0, 1, 0, E_T0);
        step(I_LD, 0, 0, 0, E_T1);
        step(I_LD, 0, 1, 0, E_T1);
        step(I_LD, 0, 1, 0, E_T2);
        step(I_LD, 0, 1, 0, RUN | GRB | BA_OUT | Y_IN);
        step(I_LD, 0, 1, 0, RUN | C_OUT | ZLOW_IN | A_ADD);
        step(I_LD, 0, 1, 0, RUN | ZLOW_OUT | MAR_IN);
        for (int k = 0; k < 3; k++) step(I_LD, 0, 0, 0, RUN | READ | MDR_IN);
        step(I_LD, 0, 1, 0, RUN | READ | MDR_IN);
        step(I_LD, 0, 1, 0, RUN | MDR_OUT | GRA | RIN);

        // st: T6 ignores mem_ready, T7 write waits one cycle
        fetch(I_ST);
        step(I_ST, 0, 1, 0, RUN | GRB | BA_OUT | Y_IN);
        step(I_ST, 0, 1, 0, RUN | C_OUT | ZLOW_IN | A_ADD);
        step(I_ST, 0, 1, 0, RUN | ZLOW_OUT | MAR_IN);
        step(I_ST, 0, 0, 0, RUN | GRA | ROUT | MDR_IN);
        step(I_ST, 0, 0, 0, RUN | WRITE);
        step(I_ST, 0, 1, 0, RUN | WRITE);

        // br not taken, then taken
        for (int t = 0; t < 2; t++) begin
            fetch(I_BR);
            step(I_BR, 0, 1, 0, RUN | GRA | ROUT | CON_IN);
            step(I_BR, 0, 1, 0, RUN | PC_OUT | Y_IN);
            step(I_BR, 0, 1, 0, RUN | C_OUT | ZLOW_IN | A_ADD);
            step(I_BR, t[0], 1, 0, (t == 0) ? RUN : (RUN | ZLOW_OUT | PC_IN));
        end

        fetch(I_ADDI);
        step(I_ADDI, 0, 1, 0, RUN | GRB | ROUT | Y_IN);
        step(I_ADDI, 0, 1, 0, RUN | C_OUT | ZLOW_IN | A_ADDI);
        step(I_ADDI, 0, 1, 0, RUN | ZLOW_OUT | GRA | RIN);

        fetch(I_LDI);
        step(I_LDI, 0, 1, 0, RUN | GRB | BA_OUT | Y_IN);
        step(I_LDI, 0, 1, 0, RUN | C_OUT | ZLOW_IN | A_ADD);
        step(I_LDI, 0, 1, 0, RUN | ZLOW_OUT | GRA | RIN);

        fetch(I_JR);
        step(I_JR, 0, 1, 0, RUN | GRA | ROUT | PC_IN);

        fetch(I_NOP);
        fetch(I_BAD);

        // sub with stop raised from T4: instruction completes, then PAUSE
        fetch(I_SUB);
        step(I_SUB, 0, 1, 0, RUN | GRB | ROUT | Y_IN);
        step(I_SUB, 0, 1, 1, RUN | GRC | ROUT | ZLOW_IN | A_SUB);
        step(I_SUB, 0, 1, 1, RUN | ZLOW_OUT | GRA | RIN);
        step(I_SUB, 0, 1, 1, 26'd0);
        step(I_SUB, 0, 1, 0, 26'd0);

        fetch(I_HALT);
        for (int k = 0; k < 20; k++) step(I_HALT, 0, 1, 0, 26'd0);

        // asynchronous reset mid-cycle out of HALT
        @(posedge clock); #2; reset = 1'b1; push(RUN);
        @(posedge clock); #1; reset = 1'b0; push(RUN);
        step(I_NOP, 0, 1, 0, E_T0);
        step(I_NOP, 0, 1, 0, E_T1);

        repeat (2) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
